alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for one ALU-class instruction at a time: decodes opcode/funct,
// sequences the logic unit through EXEC (and SHIFT2 for shifts), and pulses completion.
module alu_issue_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ZERO,
  input  logic       OVERFLOW,
  input  logic       Update_UC,
  output logic [3:0] ALUOp,
  output logic       busy,
  output logic       done,
  output logic       ALUOutWrite,
  output logic       PCWriteCond,
  output logic       OVF_EXC,
  output logic       ILLEGAL
);

  // state  | meaning
  // IDLE   | waiting for start
  // EXEC   | logic unit evaluating latched ALUOp
  // SHIFT2 | second hold cycle for the registered shifter
  // DONE   | one-cycle completion, outputs from sampled flags
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT2, DONE} state_t;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BLE  = 4'b1010;
  localparam logic [3:0] OP_BGT  = 4'b1011;
  localparam logic [3:0] OP_ADDU = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       zero_q, zero_d;
  logic       ovf_q, ovf_d;
  logic       uc_q, uc_d;

  logic [3:0] dec_op;
  logic       dec_illegal;

  always_comb begin
    dec_op      = OP_PASS;
    dec_illegal = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20:   dec_op = OP_ADD;
        6'h21:   dec_op = OP_ADDU;
        6'h22:   dec_op = OP_SUB;
        6'h24:   dec_op = OP_AND;
        6'h2A:   dec_op = OP_SLT;
        6'h00:   dec_op = OP_SLL;
        6'h02:   dec_op = OP_SRL;
        6'h03:   dec_op = OP_SRA;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h08:   dec_op = OP_ADD;
        6'h09:   dec_op = OP_ADDU;
        6'h04:   dec_op = OP_BEQ;
        6'h05:   dec_op = OP_BNE;
        6'h06:   dec_op = OP_BLE;
        6'h07:   dec_op = OP_BGT;
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  logic is_shift, is_arith, is_branch;
  assign is_shift  = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) ||
                     (op_q == OP_BLE) || (op_q == OP_BGT);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    uc_d      = uc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = dec_op;
          illegal_d = dec_illegal;
          zero_d    = 1'b0;
          ovf_d     = 1'b0;
          uc_d      = 1'b0;
          state_d   = dec_illegal ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (is_shift) begin
          state_d = SHIFT2;
        end else begin
          zero_d  = ZERO;
          ovf_d   = OVERFLOW;
          uc_d    = Update_UC;
          state_d = DONE;
        end
      end
      SHIFT2: begin
        zero_d  = ZERO;
        ovf_d   = OVERFLOW;
        uc_d    = Update_UC;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_PASS;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      uc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      uc_q      <= uc_d;
    end
  end

  // ZERO is captured alongside the other flags; no current output depends on it.
  logic unused_zero;
  assign unused_zero = zero_q;

  logic in_done;
  assign in_done = (state_q == DONE);

  assign ALUOp       = ((state_q == EXEC) || (state_q == SHIFT2)) ? op_q : OP_PASS;
  assign busy        = (state_q != IDLE);
  assign done        = in_done;
  assign ALUOutWrite = in_done && !illegal_q && !is_branch && !(is_arith && ovf_q);
  assign OVF_EXC     = in_done && is_arith && ovf_q;
  assign PCWriteCond = in_done && is_branch && uc_q;
  assign ILLEGAL     = in_done && illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: hand-computed outputs checked #1 after each edge.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ZERO;
  logic       OVERFLOW;
  logic       Update_UC;
  logic [3:0] ALUOp;
  logic       busy, done, ALUOutWrite, PCWriteCond, OVF_EXC, ILLEGAL;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .funct       (funct),
    .ZERO        (ZERO),
    .OVERFLOW    (OVERFLOW),
    .Update_UC   (Update_UC),
    .ALUOp       (ALUOp),
    .busy        (busy),
    .done        (done),
    .ALUOutWrite (ALUOutWrite),
    .PCWriteCond (PCWriteCond),
    .OVF_EXC     (OVF_EXC),
    .ILLEGAL     (ILLEGAL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, done, ALUOutWrite, PCWriteCond, OVF_EXC, ILLEGAL}
  logic [7:0] st;
  assign st = {2'b00, busy, done, ALUOutWrite, PCWriteCond, OVF_EXC, ILLEGAL};
  logic [7:0] op8;
  assign op8 = {4'b0000, ALUOp};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    funct  = fn;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; funct = '0;
    ZERO = 1'b0; OVERFLOW = 1'b0; Update_UC = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", st, 8'h00);
    chk("rst_aluop", op8, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // ADD accepted on first edge after reset release
    issue(6'h00, 6'h20);
    chk("add_exec_op", op8, 8'h01);
    chk("add_exec_st", st, 8'b0010_0000);
    step();
    chk("add_done_st", st, 8'b0011_1000);
    chk("add_done_op", op8, 8'h00);
    step();
    chk("add_idle_st", st, 8'h00);

    // addi with overflow; flag dropped after sampling must not matter
    issue(6'h08, 6'h3F);
    OVERFLOW = 1'b1;
    chk("addi_exec_op", op8, 8'h01);
    step();
    OVERFLOW = 1'b0;
    #1;
    chk("addi_ovf_st", st, 8'b0011_0010);
    step();

    // SRA holds two cycles, overflow ignored
    issue(6'h00, 6'h03);
    OVERFLOW = 1'b1;
    chk("sra_exec_op", op8, 8'h07);
    step();
    chk("sra_shift2_op", op8, 8'h07);
    chk("sra_shift2_st", st, 8'b0010_0000);
    step();
    chk("sra_done_st", st, 8'b0011_1000);
    OVERFLOW = 1'b0;
    step();

    // BEQ taken, then not taken
    issue(6'h04, 6'h00);
    Update_UC = 1'b1;
    chk("beq_exec_op", op8, 8'h08);
    step();
    Update_UC = 1'b0;
    #1;
    chk("beq_taken_st", st, 8'b0011_0100);
    step();
    issue(6'h04, 6'h00);
    step();
    chk("beq_not_taken_st", st, 8'b0011_0000);
    step();

    // illegal opcode; start held into DONE must be ignored
    @(negedge clk);
    start = 1'b1; opcode = 6'h3F; funct = 6'h20;
    @(posedge clk);
    #1;
    opcode = 6'h00;
    chk("ill_done_st", st, 8'b0011_0001);
    chk("ill_done_op", op8, 8'h00);
    step();
    chk("ill_start_ignored", st, 8'h00);
    start = 1'b0;
    step();
    chk("ill_still_idle", st, 8'h00);

    // ADDU with overflow, start held through EXEC
    @(negedge clk);
    start = 1'b1; opcode = 6'h09; funct = 6'h00;
    @(posedge clk);
    #1;
    opcode = 6'h3F;
    OVERFLOW = 1'b1;
    chk("addu_exec_op", op8, 8'h0C);
    step();
    chk("addu_done_st", st, 8'b0011_1000);
    start = 1'b0;
    OVERFLOW = 1'b0;
    step();
    chk("addu_idle_st", st, 8'h00);

    // SUB, SLT, BNE, illegal funct
    issue(6'h00, 6'h22);
    chk("sub_exec_op", op8, 8'h02);
    step();
    chk("sub_done_st", st, 8'b0011_1000);
    step();
    issue(6'h00, 6'h2A);
    chk("slt_exec_op", op8, 8'h04);
    step();
    step();
    issue(6'h05, 6'h00);
    Update_UC = 1'b1;
    chk("bne_exec_op", op8, 8'h09);
    step();
    Update_UC = 1'b0;
    chk("bne_taken_st", st, 8'b0011_0100);
    step();
    issue(6'h00, 6'h01);
    chk("ill_funct_st", st, 8'b0011_0001);
    step();

    // reset during SHIFT2 aborts with no done
    issue(6'h00, 6'h00);
    chk("sll_exec_op", op8, 8'h05);
    step();
    chk("sll_shift2_op", op8, 8'h05);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_st", st, 8'h00);
    chk("async_rst_op", op8, 8'h00);
    step();
    chk("rst_no_done", st, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    issue(6'h00, 6'h24);
    chk("and_exec_op", op8, 8'h03);
    step();
    chk("and_done_st", st, 8'b0011_1000);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
